line_buffer_window_reader: RTL
==============================

# line_buffer_window_reader

Read-side companion of the line-buffer SRAM controller. Each cycle it consumes one pixel column spanning all KER_SIZE row slots, rotates the slots into top-to-bottom order and applies the controller's top and bottom row pad masks. It inserts left and right zero-padding columns and emits strided KER_SIZE x KER_SIZE x NFMAPS windows to the MAC array over a valid/ready handshake. Horizontal padding and horizontal stride are handled here; vertical stride is already handled by the controller's `ready`.

## Interface
- KER_SIZE, 3, kernel height and width (rows/cols per window)
- BITWIDTH, 8, bits per pixel per feature map
- NFMAPS, 3, feature maps per pixel
- STRIDE, 1, horizontal stride (>=1)
- INPUT_X_DIM, 28, real pixels per row
- PAD, 1, zero columns added on each side (0..KER_SIZE-1)
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  column valid; driven by controller `ready` & SRAM read-data valid
- in_ready  out  1  column accepted when in_valid & in_ready
- in_col  in  KER_SIZE*NFMAPS*BITWIDTH  pixel per physical slot; slot s at bits [s*NFMAPS*BITWIDTH +: NFMAPS*BITWIDTH]
- wr_slot  in  KER_SIZE  one-hot slot holding newest row (controller write_en)
- top_pad_mask  in  KER_SIZE  logical-row zero mask, bit 0 = top row
- bottom_pad_mask  in  1  zero the newest (bottom) logical row
- win_valid  out  1  window valid
- win_ready  in  1  downstream accept
- win_data  out  KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH  element (r,c) at index r*KER_SIZE+c, r=0 top, c=0 left
- win_x  out  8  output column index 0..OUT_X-1
- win_row_last  out  1  window is last of its row

## Operation
- Constants: PX = INPUT_X_DIM+2*PAD; OUT_X = (PX-KER_SIZE)/STRIDE+1, integer division.
- Rotation: newest slot n = index of wr_slot. Logical row r (0=top) = physical slot (n+1+r) mod KER_SIZE. So logical row KER_SIZE-1 = slot n.
- Masking after rotation: row r zeroed if top_pad_mask[r]. Row KER_SIZE-1 zeroed if bottom_pad_mask.
- Horizontal window: KER_SIZE-column shift register; new column enters at c=KER_SIZE-1, others shift left.
- Counter pcol counts padded column index 0..PX-1.
- FSM LEFT (reset state): shift in PAD zero columns, one per cycle; in_ready=0; go to FILL. If PAD=0, go to FILL immediately.
- FSM FILL: in_ready = !win_valid | win_ready. Each transfer shifts in one masked column and increments pcol. After real column INPUT_X_DIM-1: go to RIGHT if PAD>0, else wrap pcol to 0 and return to LEFT.
- FSM RIGHT: in_ready=0. Shift in PAD zero columns, each gated by the same output-space condition. Then wrap pcol to 0 and go to LEFT.
- Window emit: when a column with index p is shifted in, with p >= KER_SIZE-1 and (p-(KER_SIZE-1)) mod STRIDE == 0, load win_data, set win_valid and set win_x = (p-(KER_SIZE-1))/STRIDE. Set win_row_last = (win_x==OUT_X-1).
- Columns past the last emitted window (STRIDE remainder) are shifted in but produce no window.
- Any shift, zero or real, happens only when the output register is free (!win_valid | win_ready).

## Timing
- Reset values: win_valid=0, win_data=0, win_x=0, win_row_last=0, shift register=0, pcol=0, state=LEFT; in_ready=0 while in LEFT.
- Latency: window appears one clk after the transfer or zero shift that completes it.
- win_valid holds, with win_data stable, until win_ready. Same-cycle win_ready plus a new completing shift replaces the window with no bubble.
- Row turnaround costs 2*PAD cycles with in_ready=0. in_valid asserted during those cycles is ignored without loss.
- Masks and wr_slot are sampled only on the accepting cycle.
- Reset mid-row discards all partial state; the next accepted column is treated as pixel 0.

## Structure
- Shared package: PX and OUT_X localparam functions, and a window element typedef (NFMAPS x BITWIDTH vector). The same typedef is used by the MAC array.
- Sub-module `slot_rotator`: combinational rotation plus masking. Inputs in_col, wr_slot and the masks; output is the logical column.
- Top level holds the FSM, pcol, the shift register and the output register.

## Test plan
- K=3, PAD=1, X=4, S=1: rows of ones, wr_slot=001, masks 0. Expect 4 windows, win_x 0..3. Window 0 has column 0 all zero; window 3 has column 2 all zero; win_row_last only at win_x=3.
- K=3, PAD=1, X=5, S=2: pixels 1..5 in every row. Expect 3 windows at win_x 0,1,2, with centre columns equal to pixels 1,3,5.
- Rotation: slots hold 10/20/30 with wr_slot=010. Expect top row 30, middle row 10, bottom row 20.
- Masks: top_pad_mask=001 -> row 0 zero. bottom_pad_mask=1 -> row 2 zero. Both set -> only row 1 nonzero.
- Backpressure: hold win_ready=0 for 5 cycles mid-row. Expect in_ready=0, win_data stable, no column lost; sequence identical to the unstalled case.
- Reset asserted after 2 columns: outputs return to reset values. The next row produces windows starting at win_x=0 with correct left padding.

Source files
------------

// File: rtl/line_buffer_window_reader_pkg.sv
// Shared types and geometry helpers for the line-buffer read side and the MAC array.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package line_buffer_window_reader_pkg;

    localparam int WIN_NFMAPS   = 3;
    localparam int WIN_BITWIDTH = 8;

    // One window element: every feature map of a single pixel.
    typedef logic [WIN_NFMAPS-1:0][WIN_BITWIDTH-1:0] win_elem_t;

    typedef enum logic [1:0] {
        ST_LEFT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RIGHT = 2'd2
    } lb_state_t;

    // Row width including the zero columns on both sides.
    function automatic int padded_x(input int x_dim, input int pad);
        return x_dim + 2 * pad;
    endfunction

    // Windows emitted per row.
    function automatic int out_x(input int x_dim, input int pad, input int ker, input int stride);
        return (padded_x(x_dim, pad) - ker) / stride + 1;
    endfunction

endpackage

// File: rtl/line_buffer_window_reader_slot_rotator.sv
// Reorders physical SRAM row slots into top-to-bottom logical rows and applies pad masks.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: in_col (slot-ordered column), wr_slot (one-hot newest slot),
//        top_pad_mask / bottom_pad_mask (row zeroing), out_col (logical column, row 0 = top).
module line_buffer_window_reader_slot_rotator
    import line_buffer_window_reader_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3
) (
    input  logic [KER_SIZE*NFMAPS*BITWIDTH-1:0] in_col,
    input  logic [KER_SIZE-1:0]                 wr_slot,
    input  logic [KER_SIZE-1:0]                 top_pad_mask,
    input  logic                                bottom_pad_mask,
    output logic [KER_SIZE*NFMAPS*BITWIDTH-1:0] out_col
);
    localparam int ELEM_W = NFMAPS * BITWIDTH;

    always_comb begin
        int newest;
        int src;
        newest  = 0;
        src     = 0;
        out_col = '0;
        for (int s = 0; s < KER_SIZE; s++) begin
            if (wr_slot[s]) newest = s;
        end
        // The slot after the newest one holds the oldest row, i.e. the top of the window.
        for (int r = 0; r < KER_SIZE; r++) begin
            src = (newest + 1 + r) % KER_SIZE;
            if (!top_pad_mask[r] && !((r == KER_SIZE - 1) && bottom_pad_mask)) begin
                out_col[r*ELEM_W +: ELEM_W] = in_col[src*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/line_buffer_window_reader.sv
// Builds padded, strided KER_SIZE x KER_SIZE windows from a stream of line-buffer columns.
// Latency: a window is valid one clk after the shift (real or zero column) that completes it.
// Backpressure: every shift waits for a free output register; in_ready drops while a window is held.
// Ports: in_valid/in_ready/in_col + wr_slot and pad masks (column input side);
//        win_valid/win_ready/win_data/win_x/win_row_last (window output side).
module line_buffer_window_reader
    import line_buffer_window_reader_pkg::*;
#(
    parameter int KER_SIZE    = 3,
    parameter int BITWIDTH    = 8,
    parameter int NFMAPS      = 3,
    parameter int STRIDE      = 1,
    parameter int INPUT_X_DIM = 28,
    parameter int PAD         = 1
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [KER_SIZE*NFMAPS*BITWIDTH-1:0]          in_col,
    input  logic [KER_SIZE-1:0]                          wr_slot,
    input  logic [KER_SIZE-1:0]                          top_pad_mask,
    input  logic                                         bottom_pad_mask,
    output logic                                         win_valid,
    input  logic                                         win_ready,
    output logic [KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH-1:0] win_data,
    output logic [7:0]                                   win_x,
    output logic                                         win_row_last
);
    localparam int PX     = padded_x(INPUT_X_DIM, PAD);
    localparam int OUT_X  = out_x(INPUT_X_DIM, PAD, KER_SIZE, STRIDE);
    localparam int ELEM_W = NFMAPS * BITWIDTH;
    localparam int COL_W  = KER_SIZE * ELEM_W;
    localparam int WIN_W  = KER_SIZE * COL_W;
    localparam int PCW    = $clog2(PX + 1);

    lb_state_t                          state_q, state_d;
    logic [PCW-1:0]                     pcol_q, pcol_d;
    logic [KER_SIZE-1:0][COL_W-1:0]     sr_q, sr_d;
    logic                               win_valid_q, win_valid_d;
    logic [WIN_W-1:0]                   win_data_q, win_data_d;
    logic [7:0]                         win_x_q, win_x_d;
    logic                               win_row_last_q, win_row_last_d;

    logic [COL_W-1:0] logical_col;
    logic [COL_W-1:0] shift_col;
    logic             shift_en;
    logic             out_free;
    int               p_idx;

    line_buffer_window_reader_slot_rotator #(
        .KER_SIZE (KER_SIZE),
        .BITWIDTH (BITWIDTH),
        .NFMAPS   (NFMAPS)
    ) u_slot_rotator (
        .in_col          (in_col),
        .wr_slot         (wr_slot),
        .top_pad_mask    (top_pad_mask),
        .bottom_pad_mask (bottom_pad_mask),
        .out_col         (logical_col)
    );

    assign out_free = !win_valid_q || win_ready;
    assign in_ready = (state_q == ST_FILL) && out_free;
    assign p_idx    = int'(pcol_q);

    always_comb begin
        state_d        = state_q;
        pcol_d         = pcol_q;
        sr_d           = sr_q;
        win_valid_d    = win_valid_q;
        win_data_d     = win_data_q;
        win_x_d        = win_x_q;
        win_row_last_d = win_row_last_q;
        shift_en       = 1'b0;
        shift_col      = '0;

        case (state_q)
            ST_LEFT: begin
                if (PAD == 0) begin
                    state_d = ST_FILL;
                end else if (out_free) begin
                    shift_en = 1'b1;
                    pcol_d   = pcol_q + PCW'(1);
                    if (pcol_q == PCW'(PAD - 1)) state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid && out_free) begin
                    shift_en  = 1'b1;
                    shift_col = logical_col;
                    if (pcol_q == PCW'(PAD + INPUT_X_DIM - 1)) begin
                        if (PAD > 0) begin
                            state_d = ST_RIGHT;
                            pcol_d  = pcol_q + PCW'(1);
                        end else begin
                            state_d = ST_LEFT;
                            pcol_d  = '0;
                        end
                    end else begin
                        pcol_d = pcol_q + PCW'(1);
                    end
                end
            end
            ST_RIGHT: begin
                if (out_free) begin
                    shift_en = 1'b1;
                    if (pcol_q == PCW'(PX - 1)) begin
                        state_d = ST_LEFT;
                        pcol_d  = '0;
                    end else begin
                        pcol_d = pcol_q + PCW'(1);
                    end
                end
            end
            default: state_d = ST_LEFT;
        endcase

        if (win_ready) win_valid_d = 1'b0;

        if (shift_en) begin
            for (int c = 0; c < KER_SIZE - 1; c++) sr_d[c] = sr_q[c + 1];
            sr_d[KER_SIZE-1] = shift_col;
            // Emit only on columns that land on the stride grid; trailing remainder columns just shift.
            if ((p_idx >= KER_SIZE - 1) && (((p_idx - (KER_SIZE - 1)) % STRIDE) == 0)) begin
                win_valid_d    = 1'b1;
                win_x_d        = 8'((p_idx - (KER_SIZE - 1)) / STRIDE);
                win_row_last_d = (((p_idx - (KER_SIZE - 1)) / STRIDE) == OUT_X - 1);
                for (int r = 0; r < KER_SIZE; r++) begin
                    for (int c = 0; c < KER_SIZE; c++) begin
                        win_data_d[(r*KER_SIZE + c)*ELEM_W +: ELEM_W] = sr_d[c][r*ELEM_W +: ELEM_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_LEFT;
            pcol_q         <= '0;
            sr_q           <= '0;
            win_valid_q    <= 1'b0;
            win_data_q     <= '0;
            win_x_q        <= '0;
            win_row_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pcol_q         <= pcol_d;
            sr_q           <= sr_d;
            win_valid_q    <= win_valid_d;
            win_data_q     <= win_data_d;
            win_x_q        <= win_x_d;
            win_row_last_q <= win_row_last_d;
        end
    end

    assign win_valid    = win_valid_q;
    assign win_data     = win_data_q;
    assign win_x        = win_x_q;
    assign win_row_last = win_row_last_q;

endmodule
